mr_muldiv_ctrl: RTL and testbench

- Sequencer for the ACC/MR/BR multiply-divide datapath.
- Converts a single start request into per-cycle control strobes for ACC and MR:
  - 16-iteration unsigned shift-add multiply, product in {ACC,MR};
  - 16-iteration restoring divide, quotient in MR, remainder in ACC.
- Sits between the instruction controller (start/op, busy/done) and the ACC/MR/ALU datapath (strobes out, status bits in).

---
 rtl/mr_muldiv_ctrl.sv | 113 +++++++++++
 tb/tb_mr_muldiv_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mr_muldiv_ctrl.sv
// Control sequencer for the ACC/MR/BR shift-add multiply
// and restoring divide datapath.
module mr_muldiv_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic op,
  input  logic mr_lsb,
  input  logic alu_sign,
  input  logic br_zero,
  output logic busy,
  output logic done,
  output logic err,
  output logic ctrl_clr_acc,
  output logic ctrl_load_mr,
  output logic ctrl_acc_add,
  output logic ctrl_acc_sub,
  output logic ctrl_shr,
  output logic ctrl_shl,
  output logic ctrl_setq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_M_ADD,
    S_M_SHIFT,
    S_D_SHIFT,
    S_D_SUB,
    S_D_TEST,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op;
  logic             r_err;
  logic             w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_INIT;
            r_op    <= op;
            r_err   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_INIT: begin
          if (!r_op) begin
            r_state <= S_M_ADD;
          end else if (br_zero) begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
          end else begin
            r_state <= S_D_SHIFT;
          end
        end
        S_M_ADD: r_state <= S_M_SHIFT;
        S_M_SHIFT: begin
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_M_ADD;
          end
        end
        S_D_SHIFT: r_state <= S_D_SUB;
        S_D_SUB:   r_state <= S_D_TEST;
        S_D_TEST: begin
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_D_SHIFT;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so reset kills them at once
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign err          = r_err;
  assign ctrl_clr_acc = (r_state == S_INIT);
  assign ctrl_load_mr = (r_state == S_INIT);
  assign ctrl_acc_sub = (r_state == S_D_SUB);
  assign ctrl_shr     = (r_state == S_M_SHIFT);
  assign ctrl_shl     = (r_state == S_D_SHIFT);
  assign ctrl_acc_add =
    ((r_state == S_M_ADD) && mr_lsb) ||
    ((r_state == S_D_TEST) && alu_sign);
  assign ctrl_setq    =
    (r_state == S_D_TEST) && !alu_sign;

endmodule

// File: tb/tb_mr_muldiv_ctrl.sv
// Bench for mr_muldiv_ctrl: drives a behavioural ACC/MR/BR
// plant and checks results against plain arithmetic.
module tb_mr_muldiv_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start, op;
  logic mr_lsb, alu_sign, br_zero;
  logic busy, done, err;
  logic ctrl_clr_acc, ctrl_load_mr;
  logic ctrl_acc_add, ctrl_acc_sub;
  logic ctrl_shr, ctrl_shl, ctrl_setq;

  logic [15:0] mr_in, br;
  logic [16:0] acc;
  logic [15:0] mr;

  int n_busy, n_done, n_add, n_sub;
  int n_shr, n_shl, n_setq, n_coll;
  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mr_muldiv_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .start(start), .op(op),
    .mr_lsb(mr_lsb), .alu_sign(alu_sign),
    .br_zero(br_zero),
    .busy(busy), .done(done), .err(err),
    .ctrl_clr_acc(ctrl_clr_acc),
    .ctrl_load_mr(ctrl_load_mr),
    .ctrl_acc_add(ctrl_acc_add),
    .ctrl_acc_sub(ctrl_acc_sub),
    .ctrl_shr(ctrl_shr),
    .ctrl_shl(ctrl_shl),
    .ctrl_setq(ctrl_setq)
  );

  assign mr_lsb   = mr[0];
  assign alu_sign = acc[15];
  assign br_zero  = (br == 16'd0);

  // acc bit 16 holds the adder carry for the multiply shift
  always @(posedge clk) begin
    if (ctrl_clr_acc)
      acc <= '0;
    else if (ctrl_acc_add)
      acc <= {1'b0, acc[15:0]} + {1'b0, br};
    else if (ctrl_acc_sub)
      acc <= {1'b0, acc[15:0] - br};
    else if (ctrl_shr)
      acc <= {1'b0, acc[16:1]};
    else if (ctrl_shl)
      acc <= {1'b0, acc[14:0], mr[15]};
    if (ctrl_load_mr)
      mr <= mr_in;
    else if (ctrl_shr)
      mr <= {acc[0], mr[15:1]};
    else if (ctrl_shl)
      mr <= {mr[14:0], 1'b0};
    else if (ctrl_setq)
      mr[0] <= 1'b1;
  end

  always @(negedge clk) begin
    if (busy)         n_busy <= n_busy + 1;
    if (done)         n_done <= n_done + 1;
    if (ctrl_acc_add) n_add  <= n_add + 1;
    if (ctrl_acc_sub) n_sub  <= n_sub + 1;
    if (ctrl_shr)     n_shr  <= n_shr + 1;
    if (ctrl_shl)     n_shl  <= n_shl + 1;
    if (ctrl_setq)    n_setq <= n_setq + 1;
    if ($countones({ctrl_clr_acc, ctrl_acc_add,
        ctrl_acc_sub, ctrl_shr, ctrl_shl}) > 1)
      n_coll <= n_coll + 1;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h required %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {ctrl_clr_acc, ctrl_load_mr,
            ctrl_acc_add, ctrl_acc_sub,
            ctrl_shr, ctrl_shl, ctrl_setq};
  endfunction

  task automatic run_op(input bit o,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input bit spam);
    int s_busy, s_done, s_add, s_sub;
    int s_shr, s_shl, s_setq, s_coll, cyc;
    logic [31:0] prod;
    logic [15:0] q, r;
    s_busy = n_busy; s_done = n_done;
    s_add = n_add;   s_sub = n_sub;
    s_shr = n_shr;   s_shl = n_shl;
    s_setq = n_setq; s_coll = n_coll;
    @(negedge clk);
    mr_in = a; br = b; op = o; start = 1'b1;
    @(negedge clk);
    if (!spam) start = 1'b0;
    chk("err_clr", err, 0);
    chk("busy_on", busy, 1);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (spam) begin
        start = 1'($urandom);
        op    = 1'($urandom);
      end
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    @(negedge clk);
    chk("busy_off", busy, 0);
    chk("done_pulse", done, 0);
    chk("done_cnt", n_done - s_done, 1);
    chk("collide", n_coll - s_coll, 0);
    if (!o) begin
      prod = 32'(a) * 32'(b);
      chk("m_prod", {acc[15:0], mr}, prod);
      chk("m_busy", n_busy - s_busy, 34);
      chk("m_shr", n_shr - s_shr, 16);
      chk("m_add", n_add - s_add, $countones(a));
      chk("m_shl", n_shl - s_shl, 0);
      chk("m_err", err, 0);
    end else if (b == 16'd0) begin
      chk("z_busy", n_busy - s_busy, 2);
      chk("z_err", err, 1);
      chk("z_shl", n_shl - s_shl, 0);
      chk("z_sub", n_sub - s_sub, 0);
    end else begin
      q = a / b;
      r = a % b;
      chk("d_quot", mr, q);
      chk("d_rem", acc[15:0], r);
      chk("d_busy", n_busy - s_busy, 50);
      chk("d_shl", n_shl - s_shl, 16);
      chk("d_sub", n_sub - s_sub, 16);
      chk("d_setq", n_setq - s_setq, $countones(q));
      chk("d_rest", n_add - s_add, 16 - $countones(q));
      chk("d_err", err, 0);
    end
  endtask

  initial begin
    n_busy = 0; n_done = 0; n_add = 0; n_sub = 0;
    n_shr = 0; n_shl = 0; n_setq = 0; n_coll = 0;
    acc = '0; mr = '0;
    rst = 1'b1; start = 1'b0; op = 1'b0;
    mr_in = '0; br = 16'd1;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_strb", strobes(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_strb", strobes(), 0);

    run_op(1'b0, 16'd13, 16'd11, 1'b0);
    run_op(1'b0, 16'hA5A5, 16'hFFFF, 1'b0);
    run_op(1'b1, 16'd100, 16'd7, 1'b0);
    run_op(1'b1, 16'd123, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("err_hold", err, 1);
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op(1'b1, 16'hFFFF, 16'h7FFF, 1'b1);
    repeat (4) @(negedge clk);
    chk("spam_idle", busy, 0);

    for (int i = 0; i < 6; i++) begin
      run_op(1'b0, 16'($urandom), 16'($urandom), 1'b0);
      run_op(1'b1, 16'($urandom),
             16'($urandom_range(1, 16'h7FFF)), 1'b0);
    end

    @(negedge clk);
    mr_in = 16'd100; br = 16'd7; op = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_err", err, 0);
    chk("ar_strb", strobes(), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_strb", strobes(), 0);
    chk("post_busy", busy, 0);
    run_op(1'b0, 16'd300, 16'd201, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
